// File: rtl/uart_tx_sched.sv
// uart_tx_sched: APB master that shares the UART core TX path among
// NUM_REQ byte-stream requesters. It arbitrates round-robin and holds
// packet lock, polls the UART status register until the TX FIFO has room,
// then writes the byte into the UART data register.
module uart_tx_sched #(
  parameter int          NUM_REQ   = 4,
  parameter logic [31:0] STAT_ADDR = 32'h04,
  parameter logic [31:0] DATA_ADDR = 32'h00,
  parameter int          TXFF_BIT  = 1
) (
  input  logic                 pclk,
  input  logic                 prst_n,
  input  logic                 en,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 busy,
  output logic [31:0]          m_paddr,
  output logic                 m_psel,
  output logic                 m_penable,
  output logic                 m_pwrite,
  output logic [31:0]          m_pwdata,
  input  logic [31:0]          m_prdata
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_SETUP,
    S_RD_ACCESS,
    S_WR_SETUP,
    S_WR_ACCESS
  } state_t;

  state_t             state, state_nx;
  logic               lock;
  logic [IW-1:0]      rr_ptr;
  logic [IW-1:0]      own_idx;
  logic [7:0]         byte_q;
  logic               last_q;
  logic [NUM_REQ-1:0] eligible;
  logic               found;
  logic [IW-1:0]      win_idx;
  logic               accept;
  logic               tx_full;
  logic               prdata_unused;

  // Only one status bit matters; the rest of the read word is deliberately ignored.
  assign prdata_unused = ^m_prdata;
  assign tx_full       = m_prdata[TXFF_BIT];

  // Index that is 'offs' positions after 'base', wrapping at NUM_REQ-1 -> 0.
  function automatic logic [IW-1:0] rr_index(input logic [IW-1:0] base, input int offs);
    int sum;
    sum = int'(base) + offs;
    if (sum >= NUM_REQ) sum = sum - NUM_REQ;
    return IW'(sum);
  endfunction

  // Winner search: locked owner only while a packet is open, else round-robin from rr_ptr+1.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path can infer a latch.
    eligible  = lock ? (req_valid & grant) : req_valid;
    found     = 1'b0;
    win_idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!found && eligible[rr_index(rr_ptr, k)]) begin
        found   = 1'b1;
        win_idx = rr_index(rr_ptr, k);
      end
    end
    accept    = (state == S_IDLE) && en && found;
    req_ready = '0;
    if (accept) req_ready[win_idx] = 1'b1;
  end

  // Next-state logic for the read-poll / write sequence.
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:      if (accept) state_nx = S_RD_SETUP;
      S_RD_SETUP:  state_nx = S_RD_ACCESS;
      S_RD_ACCESS: state_nx = tx_full ? S_RD_SETUP : S_WR_SETUP;
      S_WR_SETUP:  state_nx = S_WR_ACCESS;
      S_WR_ACCESS: state_nx = S_IDLE;
      default:     state_nx = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge pclk or negedge prst_n) begin
    // NOTE: sequential state is updated with non-blocking assignments only.
    if (!prst_n) state <= S_IDLE;
    else         state <= state_nx;
  end

  // Byte capture, ownership, packet lock and round-robin pointer.
  always_ff @(posedge pclk or negedge prst_n) begin
    if (!prst_n) begin
      byte_q  <= '0;
      last_q  <= 1'b0;
      own_idx <= '0;
      grant   <= '0;
      lock    <= 1'b0;
      rr_ptr  <= IW'(NUM_REQ - 1);
    end else begin
      if (accept) begin
        byte_q  <= req_data[8*win_idx +: 8];
        last_q  <= req_last[win_idx];
        own_idx <= win_idx;
        grant   <= req_ready;
      end
      if (state == S_WR_ACCESS) begin
        if (last_q) begin
          lock   <= 1'b0;
          rr_ptr <= own_idx;
          grant  <= '0;
        end else begin
          lock   <= 1'b1;
        end
      end
    end
  end

  // Registered APB outputs, loaded from the state being entered; address/data hold in IDLE.
  always_ff @(posedge pclk or negedge prst_n) begin
    if (!prst_n) begin
      m_psel    <= 1'b0;
      m_penable <= 1'b0;
      m_pwrite  <= 1'b0;
      m_paddr   <= '0;
      m_pwdata  <= '0;
    end else begin
      m_psel    <= (state_nx != S_IDLE);
      m_penable <= (state_nx == S_RD_ACCESS) || (state_nx == S_WR_ACCESS);
      m_pwrite  <= (state_nx == S_WR_SETUP)  || (state_nx == S_WR_ACCESS);
      if (state_nx == S_RD_SETUP) m_paddr <= STAT_ADDR;
      if (state_nx == S_WR_SETUP) begin
        m_paddr  <= DATA_ADDR;
        m_pwdata <= {24'b0, byte_q};
      end
    end
  end

  assign busy = (state != S_IDLE) || lock;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched: requester queues drive the byte streams,
// a status-register model supplies TX-full polls, and a scoreboard of expected
// (requester, byte) writes is checked against each APB data write.
module tb_uart_tx_sched;

  localparam int          N    = 4;
  localparam logic [31:0] STAT = 32'h04;
  localparam logic [31:0] DATA = 32'h00;

  logic           pclk = 1'b0;
  logic           prst_n = 1'b0;
  logic           en = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [8*N-1:0] req_data = '0;
  logic [N-1:0]   req_last = '0;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   grant;
  logic           busy;
  logic [31:0]    m_paddr;
  logic           m_psel;
  logic           m_penable;
  logic           m_pwrite;
  logic [31:0]    m_pwdata;
  logic [31:0]    m_prdata;

  typedef struct {
    int         idx;
    logic [7:0] data;
  } exp_t;

  exp_t       exp_q[$];
  logic [8:0] src_q[N][$];
  bit         hold[N];
  int         full_cnt = 0;
  bit         rd_dec = 0;
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  int         rd_cnt = 0;
  int         wr_cnt = 0;
  int         rdy_cnt[N] = '{default: 0};
  int         acc_cyc[$];
  int         last_acc = 0;
  int         last_wr = 0;
  bit         in_flight = 0;
  int         busy_drop = 0;

  always #5 pclk = ~pclk;

  // Status register: TX-full while full_cnt > 0; other bits are noise the DUT must ignore.
  assign m_prdata = (full_cnt > 0) ? 32'h0000_0002 : 32'hFFFF_FFFD;

  uart_tx_sched #(.NUM_REQ(N), .STAT_ADDR(STAT), .DATA_ADDR(DATA), .TXFF_BIT(1)) dut (
    .pclk(pclk), .prst_n(prst_n), .en(en),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready), .grant(grant), .busy(busy),
    .m_paddr(m_paddr), .m_psel(m_psel), .m_penable(m_penable),
    .m_pwrite(m_pwrite), .m_pwdata(m_pwdata), .m_prdata(m_prdata)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Requester drivers and status-model update, just after each rising edge.
  always @(posedge pclk) begin
    logic [8:0] head;
    cyc++;
    #1;
    if (rd_dec) begin
      if (full_cnt > 0) full_cnt--;
      rd_dec = 0;
    end
    for (int i = 0; i < N; i++) begin
      if (src_q[i].size() > 0 && !hold[i]) begin
        head             = src_q[i][0];
        req_valid[i]     = 1'b1;
        req_data[8*i +: 8] = head[7:0];
        req_last[i]      = head[8];
      end else begin
        req_valid[i]     = 1'b0;
      end
    end
  end

  // Monitor on the falling edge: accepts, status reads, and scoreboard compare on data writes.
  always @(negedge pclk) begin
    exp_t        e;
    logic [N-1:0] g;
    if (prst_n) begin
      if (in_flight && !busy) busy_drop++;
      for (int i = 0; i < N; i++) begin
        if (req_ready[i]) begin
          rdy_cnt[i]++;
          if (req_valid[i]) begin
            void'(src_q[i].pop_front());
            acc_cyc.push_back(cyc);
            last_acc  = cyc;
            in_flight = 1;
          end
        end
      end
      if (m_psel && m_penable && !m_pwrite) begin
        rd_cnt++;
        rd_dec = 1;
        check("rd_addr", m_paddr, STAT);
      end
      if (m_psel && m_penable && m_pwrite) begin
        wr_cnt++;
        last_wr   = cyc;
        in_flight = 0;
        check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          g = '0;
          g[e.idx] = 1'b1;
          check("wr_grant", 32'(grant), 32'(g));
          check("wr_data", m_pwdata, {24'b0, e.data});
          check("wr_addr", m_paddr, DATA);
          check("wr_busy", 32'(busy), 32'd1);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge pclk);
    #2;
  endtask

  function automatic bit src_empty();
    for (int i = 0; i < N; i++) if (src_q[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic push_src(input int idx, input logic last, input logic [7:0] data, input bit expect_wr);
    exp_t e;
    src_q[idx].push_back({last, data});
    if (expect_wr) begin
      e.idx  = idx;
      e.data = data;
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_idle(input string tag, input int max);
    int k;
    k = 0;
    while (k < max && !(exp_q.size() == 0 && src_empty() && !busy && !in_flight)) begin
      step(1);
      k++;
    end
    check({tag, "_timeout"}, 32'(k < max), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0, w0, a0, a1, k;

    // Reset state.
    step(2);
    check("rst_psel", 32'(m_psel), 32'd0);
    check("rst_penable", 32'(m_penable), 32'd0);
    check("rst_pwrite", 32'(m_pwrite), 32'd0);
    check("rst_paddr", m_paddr, 32'd0);
    check("rst_pwdata", m_pwdata, 32'd0);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd0);
    prst_n = 1'b1;
    step(1);
    en = 1'b1;

    // Single byte 0xA5 from requester 0, FIFO not full.
    r0 = rd_cnt; w0 = wr_cnt; a0 = rdy_cnt[0];
    push_src(0, 1'b1, 8'hA5, 1);
    wait_idle("t1", 40);
    check("t1_reads", 32'(rd_cnt - r0), 32'd1);
    check("t1_writes", 32'(wr_cnt - w0), 32'd1);
    check("t1_ready_pulse", 32'(rdy_cnt[0] - a0), 32'd1);
    check("t1_latency", 32'(last_wr - last_acc), 32'd4);
    check("t1_pwdata_hold", m_pwdata, 32'h0000_00A5);
    check("t1_paddr_hold", m_paddr, DATA);
    check("t1_psel_idle", 32'(m_psel), 32'd0);

    // Reset during WR_SETUP: APB drops at once, byte lost, pointer back to NUM_REQ-1.
    push_src(0, 1'b1, 8'h55, 0);
    k = 0;
    while (k < 30 && !(m_psel && m_pwrite && !m_penable)) begin
      step(1);
      k++;
    end
    check("t5_reach_wr_setup", 32'(k < 30), 32'd1);
    prst_n = 1'b0;
    #1;
    in_flight = 0;
    check("t5_psel", 32'(m_psel), 32'd0);
    check("t5_penable", 32'(m_penable), 32'd0);
    check("t5_pwrite", 32'(m_pwrite), 32'd0);
    check("t5_grant", 32'(grant), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    step(2);
    prst_n = 1'b1;
    step(1);

    // All four valid, single-byte packets, pointer at 3: order 0,1,2,3,0, five cycles apart.
    acc_cyc.delete();
    push_src(0, 1'b1, 8'h10, 1);
    push_src(1, 1'b1, 8'h11, 1);
    push_src(2, 1'b1, 8'h12, 1);
    push_src(3, 1'b1, 8'h13, 1);
    push_src(0, 1'b1, 8'h14, 0);
    exp_q.push_back('{idx: 0, data: 8'h14});
    wait_idle("t2", 80);
    check("t2_accepts", 32'(acc_cyc.size()), 32'd5);
    if (acc_cyc.size() >= 5)
      for (int i = 1; i < 5; i++) check("t2_spacing", 32'(acc_cyc[i] - acc_cyc[i-1]), 32'd5);

    // Requester 1 three-byte packet with requester 2 waiting: no interleave.
    a1 = rdy_cnt[2];
    push_src(1, 1'b0, 8'h21, 1);
    push_src(1, 1'b0, 8'h22, 1);
    push_src(1, 1'b1, 8'h23, 1);
    push_src(2, 1'b1, 8'h31, 1);
    wait_idle("t3", 80);
    check("t3_req2_once", 32'(rdy_cnt[2] - a1), 32'd1);

    // TX FIFO full for three polls: four status reads, one write, busy held.
    r0 = rd_cnt; w0 = wr_cnt;
    full_cnt = 3;
    push_src(3, 1'b1, 8'h44, 1);
    wait_idle("t4", 60);
    check("t4_reads", 32'(rd_cnt - r0), 32'd4);
    check("t4_writes", 32'(wr_cnt - w0), 32'd1);
    check("t4_latency", 32'(last_wr - last_acc), 32'd10);
    check("t4_busy_held", 32'(busy_drop), 32'd0);

    // en=0 blocks new accepts; en=1 accepts on the next IDLE cycle.
    en = 1'b0;
    a0 = rdy_cnt[3];
    push_src(3, 1'b1, 8'h66, 1);
    step(10);
    check("t6_no_ready", 32'(rdy_cnt[3] - a0), 32'd0);
    check("t6_idle_busy", 32'(busy), 32'd0);
    check("t6_idle_psel", 32'(m_psel), 32'd0);
    en = 1'b1;
    step(1);
    check("t6_ready_now", 32'(rdy_cnt[3] - a0), 32'd1);
    wait_idle("t6", 40);

    // Locked requester drops valid mid-packet: others stay blocked, lock and grant held.
    a0 = rdy_cnt[0];
    a1 = rdy_cnt[1];
    push_src(0, 1'b0, 8'h71, 1);
    push_src(0, 1'b1, 8'h72, 1);
    push_src(1, 1'b1, 8'h81, 1);
    k = 0;
    while (k < 20 && rdy_cnt[0] == a0) begin
      step(1);
      k++;
    end
    check("t7_first_accept", 32'(k < 20), 32'd1);
    hold[0] = 1'b1;
    step(12);
    check("t7_others_blocked", 32'(rdy_cnt[1] - a1), 32'd0);
    check("t7_lock_busy", 32'(busy), 32'd1);
    check("t7_grant_held", 32'(grant), 32'h1);
    hold[0] = 1'b0;
    wait_idle("t7", 60);
    check("t7_req1_after", 32'(rdy_cnt[1] - a1), 32'd1);
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
